// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared M-extension funct3 encodings and divider state type
package div_unit_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_CNT_W = 6;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - picks quotient or remainder magnitude and applies the result sign
import div_unit_pkg::*;

module div_sign_fix #(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] rem,
   input  logic [2:0]      funct3,
   input  logic            q_neg,
   input  logic            r_neg,
   output logic [XLEN-1:0] result
);

   logic use_rem;

   assign use_rem = (funct3 == F_REM) || (funct3 == F_REMU);
   assign result  = use_rem ? (r_neg ? -rem : rem)
                            : (q_neg ? -quo : quo);

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
import div_unit_pkg::*;

module div_unit #(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] div_out
);

   div_state_t       state;
   logic [2:0]       f3;
   logic             q_neg;
   logic             r_neg;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  rem;
   logic [XLEN:0]    dsr;
   logic [CNT_W-1:0] counter;

   logic             is_signed;
   logic             sign1;
   logic             sign2;
   logic [XLEN-1:0]  abs1;
   logic [XLEN-1:0]  abs2;
   logic             div_zero;
   logic             overflow;
   logic             special;

   logic [XLEN:0]    shifted;
   logic             fits;
   logic [XLEN-1:0]  diff;
   logic [XLEN-1:0]  rem_next;
   logic [XLEN-1:0]  quo_next;

   logic [XLEN-1:0]  fix_quo;
   logic [XLEN-1:0]  fix_rem;
   logic [2:0]       fix_f3;
   logic             fix_qn;
   logic             fix_rn;
   logic [XLEN-1:0]  fix_result;

   assign is_signed = ~funct3[0];
   assign sign1     = is_signed & rs1_value[XLEN-1];
   assign sign2     = is_signed & rs2_value[XLEN-1];
   assign abs1      = sign1 ? -rs1_value : rs1_value;
   assign abs2      = sign2 ? -rs2_value : rs2_value;
   assign div_zero  = (rs2_value == '0);
   assign overflow  = is_signed && (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value == '1);
   assign special   = div_zero | overflow;

   // One restoring step: shift the dividend MSB into the partial remainder, keep the trial difference if it fits.
   assign shifted  = {rem, quo[XLEN-1]};
   assign fits     = (shifted >= dsr);
   assign diff     = XLEN'(shifted - dsr);
   assign rem_next = fits ? diff : shifted[XLEN-1:0];
   assign quo_next = {quo[XLEN-2:0], fits};

   // In IDLE the sign fixer forms the special-case results straight from the operands.
   always_comb begin
      fix_quo = quo_next;
      fix_rem = rem_next;
      fix_f3  = f3;
      fix_qn  = q_neg;
      fix_rn  = r_neg;
      if (state != CALC) begin
         fix_quo = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
         fix_rem = div_zero ? abs1 : '0;
         fix_f3  = funct3;
         fix_qn  = 1'b0;
         fix_rn  = sign1;
      end
   end

   div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .quo    (fix_quo),
      .rem    (fix_rem),
      .funct3 (fix_f3),
      .q_neg  (fix_qn),
      .r_neg  (fix_rn),
      .result (fix_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         div_out <= '0;
         f3      <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         quo     <= '0;
         rem     <= '0;
         dsr     <= '0;
         counter <= '0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     f3      <= funct3;
                     q_neg   <= sign1 ^ sign2;
                     r_neg   <= sign1;
                     quo     <= abs1;
                     rem     <= '0;
                     dsr     <= {1'b0, abs2};
                     counter <= '0;
                     if (special) begin
                        div_out <= fix_result;
                        done    <= 1'b1;
                        state   <= DONE;
                     end else begin
                        busy  <= 1'b1;
                        state <= CALC;
                     end
                  end
               end
               CALC: begin
                  quo     <= quo_next;
                  rem     <= rem_next;
                  counter <= counter + 1'b1;
                  if (counter == CNT_W'(XLEN-1)) begin
                     div_out <= fix_result;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = F_DIVU;
   logic [31:0] rs1_value = '0;
   logic [31:0] rs2_value = '0;
   logic        busy;
   logic        done;
   logic [31:0] div_out;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .kill      (kill),
      .funct3    (funct3),
      .rs1_value (rs1_value),
      .rs2_value (rs2_value),
      .busy      (busy),
      .done      (done),
      .div_out   (div_out)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend).
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0)
         return f[1] ? a : 32'hFFFF_FFFF;
      if (f[0] == 1'b0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return f[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0)
         return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return 1;
      return 33;
   endfunction

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int poke);
      int cyc;
      int busy_errs;
      int lat;
      lat = ref_latency(f, a, b);
      funct3    = f;
      rs1_value = a;
      rs2_value = b;
      start     = 1'b1;
      step();
      start     = 1'b0;
      funct3    = F_REMU;
      rs1_value = $urandom;
      rs2_value = $urandom;
      cyc       = 1;
      busy_errs = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy !== 1'b1)
            busy_errs++;
         if (cyc == poke) begin
            funct3    = F_REMU;
            rs1_value = 32'd50;
            rs2_value = 32'd3;
            start     = 1'b1;
         end
         step();
         start = 1'b0;
         cyc++;
      end
      check({name, " done"}, 32'(done), 32'd1);
      check({name, " latency"}, 32'(cyc), 32'(lat));
      check({name, " result"}, div_out, exp);
      check({name, " busy in calc"}, 32'(busy_errs), 32'd0);
      check({name, " busy at done"}, 32'(busy), 32'd0);
      step();
      check({name, " done pulse"}, 32'(done), 32'd0);
      check({name, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int saw_done;
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;

      vecs[0]  = '{F_DIVU, 32'd100,        32'd7,        32'd14};
      vecs[1]  = '{F_REMU, 32'd100,        32'd7,        32'd2};
      vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD};
      vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF};
      vecs[4]  = '{F_REM,  32'd7,          32'hFFFF_FFFE, 32'd1};
      vecs[5]  = '{F_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF};
      vecs[6]  = '{F_REMU, 32'hDEAD_BEEF,  32'd0,        32'hDEAD_BEEF};
      vecs[7]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[8]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      vecs[9]  = '{F_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF};
      vecs[10] = '{F_DIV,  32'h8000_0000,  32'd2,        32'hC000_0000};
      vecs[11] = '{F_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2};
      vecs[12] = '{F_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE};
      vecs[13] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      vecs[14] = '{F_REM,  32'h8000_0000,  32'd0,        32'h8000_0000};
      vecs[15] = '{F_REMU, 32'hFFFF_FFFF,  32'd16,       32'd15};
      vecs[16] = '{F_DIV,  32'h7FFF_FFFF,  32'hFFFF_FFFF, 32'h8000_0001};

      repeat (2) step();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset div_out", div_out, 32'd0);
      rst_n = 1'b1;
      step();

      // Consecutive entries start in the cycle right after the previous done.
      for (int i = 0; i < 17; i++)
         run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

      run_op("pre-kill", F_DIVU, 32'd100, 32'd7, 32'd14, 0);
      funct3    = F_DIVU;
      rs1_value = 32'd1000;
      rs2_value = 32'd10;
      start     = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      kill = 1'b1;
      start = 1'b1;
      step();
      kill = 1'b0;
      start = 1'b0;
      check("kill busy", 32'(busy), 32'd0);
      check("kill done", 32'(done), 32'd0);
      check("kill div_out", div_out, 32'd14);
      saw_done = 0;
      repeat (40) begin
         step();
         if (done === 1'b1)
            saw_done = 1;
      end
      check("kill no done", 32'(saw_done), 32'd0);

      run_op("start ignored", F_DIVU, 32'd200, 32'd7, 32'd28, 5);

      funct3    = F_DIVU;
      rs1_value = 32'd100;
      rs2_value = 32'd7;
      start     = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst done", 32'(done), 32'd0);
      check("async rst div_out", div_out, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post rst done", 32'(done), 32'd0);
      run_op("after reset", F_DIVU, 32'd9, 32'd3, 32'd3, 0);

      for (int n = 0; n < 150; n++) begin
         rf  = 3'(32'd4 + $urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: rb = ra >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op($sformatf("rand%0d", n), rf, ra, rb, ref_result(rf, ra, rb), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
